// File: rtl/dr_pkg.sv
// rtl/dr_pkg.sv - shared types and constants for the multi-lane prediction inspector
package dr_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } dr_state_e;

    localparam int MISS_CNT_W = 16;
    localparam int DEF_OFF_W  = 32;
    localparam int DEF_COL_W  = 16;

endpackage

// File: rtl/dr_insp_multi_if.sv
// rtl/dr_insp_multi_if.sv - prediction beat in/out bundle between front end, inspector and SpMV datapath
interface dr_insp_multi_if
    import dr_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OFF_W = DEF_OFF_W,
    parameter int COL_W = DEF_COL_W
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*OFF_W-1:0] offset1;
    logic [LANES*OFF_W-1:0] offset2;
    logic [LANES*OFF_W-1:0] in_prediction;
    logic [LANES*COL_W-1:0] col1;
    logic [LANES*COL_W-1:0] col2;
    logic [LANES*COL_W-1:0] in_prediction_col;
    logic                   out_valid;
    logic [LANES*OFF_W-1:0] out_prediction;
    logic [LANES*COL_W-1:0] out_prediction_col;
    logic [LANES-1:0]       out_lane_miss;

    modport master (
        output in_valid, offset1, offset2, in_prediction, col1, col2, in_prediction_col,
        input  in_ready, out_valid, out_prediction, out_prediction_col, out_lane_miss
    );

    modport slave (
        input  in_valid, offset1, offset2, in_prediction, col1, col2, in_prediction_col,
        output in_ready, out_valid, out_prediction, out_prediction_col, out_lane_miss
    );
endinterface

// File: rtl/dr_lane_cmp.sv
// rtl/dr_lane_cmp.sv - one lane: offset/column differences for S1 and predicted-vs-actual compare for S2
module dr_lane_cmp
    import dr_pkg::*;
#(
    parameter int OFF_W     = DEF_OFF_W,
    parameter int COL_W     = DEF_COL_W,
    parameter int CHECK_COL = 1
) (
    input  logic [OFF_W-1:0] i_offset1,
    input  logic [OFF_W-1:0] i_offset2,
    input  logic [COL_W-1:0] i_col1,
    input  logic [COL_W-1:0] i_col2,
    output logic [OFF_W-1:0] o_nnz,
    output logic [COL_W-1:0] o_colidx,
    input  logic [OFF_W-1:0] i_nnz_q,
    input  logic [COL_W-1:0] i_colidx_q,
    input  logic [OFF_W-1:0] i_pred,
    input  logic [COL_W-1:0] i_pred_col,
    output logic             o_miss
);
    logic w_nnz_miss;
    logic w_col_miss;

    // Differences wrap modulo the field width; no sign extension is wanted.
    assign o_nnz    = i_offset1 - i_offset2;
    assign o_colidx = i_col1 - i_col2;

    assign w_nnz_miss = (i_nnz_q != i_pred);
    assign w_col_miss = (i_colidx_q != i_pred_col);
    assign o_miss     = w_nnz_miss || ((CHECK_COL != 0) && w_col_miss);
endmodule

// File: rtl/dr_insp_multi.sv
// rtl/dr_insp_multi.sv - multi-lane NNZ/column prediction inspector with mispredict flush and miss counter
module dr_insp_multi
    import dr_pkg::*;
#(
    parameter int OFF_W      = DEF_OFF_W,
    parameter int COL_W      = DEF_COL_W,
    parameter int LANES      = 4,
    parameter int FLUSH_HOLD = 4,
    parameter int CHECK_COL  = 1,
    parameter int CNT_W      = MISS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    dr_insp_multi_if.slave   bus,
    input  logic             cnt_clr,
    output logic             flush,
    output logic [CNT_W-1:0] miss_count
);
    localparam int HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

    dr_state_e               r_state;
    logic [HOLD_W-1:0]       r_hold;

    logic [LANES-1:0][OFF_W-1:0] w_nnz;
    logic [LANES-1:0][COL_W-1:0] w_colidx;
    logic [LANES-1:0]            w_lane_miss;

    logic [LANES-1:0][OFF_W-1:0] r_s1_nnz;
    logic [LANES-1:0][COL_W-1:0] r_s1_colidx;
    logic [LANES*OFF_W-1:0]      r_s1_pred;
    logic [LANES*COL_W-1:0]      r_s1_pred_col;
    logic                        r_v1;

    logic [LANES*OFF_W-1:0]      r_s2_pred;
    logic [LANES*COL_W-1:0]      r_s2_pred_col;
    logic [LANES-1:0]            r_s2_lane_miss;
    logic                        r_v2;
    logic                        r_s2_any;

    logic w_run;
    logic w_accept;
    logic w_enter_flush;
    logic w_s2_load;
    logic w_cnt_sat;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            dr_lane_cmp #(
                .OFF_W     (OFF_W),
                .COL_W     (COL_W),
                .CHECK_COL (CHECK_COL)
            ) u_cmp (
                .i_offset1  (bus.offset1[g*OFF_W +: OFF_W]),
                .i_offset2  (bus.offset2[g*OFF_W +: OFF_W]),
                .i_col1     (bus.col1[g*COL_W +: COL_W]),
                .i_col2     (bus.col2[g*COL_W +: COL_W]),
                .o_nnz      (w_nnz[g]),
                .o_colidx   (w_colidx[g]),
                .i_nnz_q    (r_s1_nnz[g]),
                .i_colidx_q (r_s1_colidx[g]),
                .i_pred     (r_s1_pred[g*OFF_W +: OFF_W]),
                .i_pred_col (r_s1_pred_col[g*COL_W +: COL_W]),
                .o_miss     (w_lane_miss[g])
            );
        end
    endgenerate

    assign w_run         = (r_state == RUN);
    assign bus.in_ready  = w_run;
    assign w_accept      = bus.in_valid && w_run;
    assign w_enter_flush = w_run && r_s2_any;
    // Entering flush squashes whatever is in S1 and whatever is being accepted on that edge.
    assign w_s2_load     = r_v1 && w_run && !w_enter_flush;
    assign w_cnt_sat     = &miss_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_nnz               <= '0;
            r_s1_colidx            <= '0;
            r_s1_pred              <= '0;
            r_s1_pred_col          <= '0;
            r_v1                   <= 1'b0;
            r_s2_pred              <= '0;
            r_s2_pred_col          <= '0;
            r_s2_lane_miss         <= '0;
            r_v2                   <= 1'b0;
            r_s2_any               <= 1'b0;
            bus.out_valid          <= 1'b0;
            bus.out_prediction     <= '0;
            bus.out_prediction_col <= '0;
            bus.out_lane_miss      <= '0;
        end else begin
            r_v1 <= w_accept && !w_enter_flush;
            if (w_accept) begin
                r_s1_nnz      <= w_nnz;
                r_s1_colidx   <= w_colidx;
                r_s1_pred     <= bus.in_prediction;
                r_s1_pred_col <= bus.in_prediction_col;
            end

            r_v2           <= w_s2_load;
            r_s2_any       <= w_s2_load && (|w_lane_miss);
            r_s2_lane_miss <= w_lane_miss;
            r_s2_pred      <= r_s1_pred;
            r_s2_pred_col  <= r_s1_pred_col;

            bus.out_valid     <= r_v2;
            bus.out_lane_miss <= r_v2 ? r_s2_lane_miss : '0;
            if (r_v2) begin
                bus.out_prediction     <= r_s2_pred;
                bus.out_prediction_col <= r_s2_pred_col;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RUN;
            r_hold  <= '0;
            flush   <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (r_s2_any) begin
                        r_state <= FLUSH;
                        r_hold  <= HOLD_W'(FLUSH_HOLD - 1);
                        flush   <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (r_hold == '0) begin
                        r_state <= RUN;
                        flush   <= 1'b0;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    flush   <= 1'b0;
                end
            endcase
        end
    end

    // Clear takes priority over a miss landing on the same edge.
    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            miss_count <= '0;
        end else if (w_enter_flush && !w_cnt_sat) begin
            miss_count <= miss_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_dr_insp_multi.sv
// tb/tb_dr_insp_multi.sv - randomized bench for dr_insp_multi against a cycle-timeline reference model
module tb_dr_insp_multi;
    localparam int L    = 4;
    localparam int OW   = 32;
    localparam int CW   = 16;
    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_m, clr_a;
    logic        flush_m, flush_a;
    logic [15:0] cnt_m;
    logic [3:0]  cnt_a;

    always #5 clk = ~clk;

    dr_insp_multi_if #(.LANES(L), .OFF_W(OW), .COL_W(CW)) bm ();
    dr_insp_multi_if #(.LANES(L), .OFF_W(OW), .COL_W(CW)) ba ();

    dr_insp_multi #(.OFF_W(OW), .COL_W(CW), .LANES(L), .FLUSH_HOLD(4), .CHECK_COL(1), .CNT_W(16)) u_main (
        .clk(clk), .rst(rst), .bus(bm), .cnt_clr(clr_m), .flush(flush_m), .miss_count(cnt_m));

    dr_insp_multi #(.OFF_W(OW), .COL_W(CW), .LANES(L), .FLUSH_HOLD(1), .CHECK_COL(0), .CNT_W(4)) u_alt (
        .clk(clk), .rst(rst), .bus(ba), .cnt_clr(clr_a), .flush(flush_a), .miss_count(cnt_a));

    int fh   [2] = '{4, 1};
    bit chkc [2] = '{1'b1, 1'b0};
    int cmax [2] = '{65535, 15};

    bit           ev_valid [2][MAXC];
    logic [3:0]   ev_miss  [2][MAXC];
    logic [127:0] ev_pred  [2][MAXC];
    logic [63:0]  ev_predc [2][MAXC];
    bit           ev_flush [2][MAXC];
    bit           ev_inc   [2][MAXC];
    int           squash_to[2];
    int           m_cnt    [2];

    bit           dv   [2];
    logic [127:0] d_o1 [2];
    logic [127:0] d_o2 [2];
    logic [127:0] d_p  [2];
    logic [63:0]  d_c1 [2];
    logic [63:0]  d_c2 [2];
    logic [63:0]  d_pc [2];
    bit           d_clr[2];

    int cyc;
    bit started;
    int checks;
    int errors;

    task automatic chk(input string tag, input int d, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc%0d observed=%h expected=%h", tag, d, cyc, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_miss(input int d);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < L; i++) begin
            logic [31:0] nnz;
            logic [15:0] col;
            nnz = d_o1[d][i*OW +: OW] - d_o2[d][i*OW +: OW];
            col = d_c1[d][i*CW +: CW] - d_c2[d][i*CW +: CW];
            m[i] = (nnz != d_p[d][i*OW +: OW]) || (chkc[d] && (col != d_pc[d][i*CW +: CW]));
        end
        return m;
    endfunction

    task automatic mk_beat(input int d, input logic [3:0] bad_nnz, input logic [3:0] bad_col);
        for (int i = 0; i < L; i++) begin
            logic [31:0] a, b, n;
            logic [15:0] ca, cb, cn;
            a  = $urandom;
            b  = $urandom;
            n  = a - b;
            if (bad_nnz[i]) n = n + 32'd1;
            ca = 16'($urandom);
            cb = 16'($urandom);
            cn = ca - cb;
            if (bad_col[i]) cn = cn + 16'd1;
            d_o1[d][i*OW +: OW] = a;
            d_o2[d][i*OW +: OW] = b;
            d_p[d][i*OW +: OW]  = n;
            d_c1[d][i*CW +: CW] = ca;
            d_c2[d][i*CW +: CW] = cb;
            d_pc[d][i*CW +: CW] = cn;
        end
        dv[d] = 1'b1;
    endtask

    task automatic idle(input int d);
        dv[d] = 1'b0;
    endtask

    task automatic apply();
        bm.in_valid = dv[0]; bm.offset1 = d_o1[0]; bm.offset2 = d_o2[0]; bm.in_prediction = d_p[0];
        bm.col1 = d_c1[0]; bm.col2 = d_c2[0]; bm.in_prediction_col = d_pc[0];
        ba.in_valid = dv[1]; ba.offset1 = d_o1[1]; ba.offset2 = d_o2[1]; ba.in_prediction = d_p[1];
        ba.col1 = d_c1[1]; ba.col2 = d_c2[1]; ba.in_prediction_col = d_pc[1];
        clr_m = d_clr[0];
        clr_a = d_clr[1];
    endtask

    // Timeline model: an accepted, unsquashed beat appears two edges later; a miss
    // schedules its flush window, blocks input while flush is high and squashes two younger beats.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                for (int k = cyc; k < MAXC; k++) begin
                    ev_valid[d][k] = 1'b0;
                    ev_flush[d][k] = 1'b0;
                    ev_inc[d][k]   = 1'b0;
                end
                m_cnt[d]     = 0;
                squash_to[d] = -1;
            end else begin
                if (dv[d] && !ev_flush[d][cyc-1] && (cyc > squash_to[d])) begin
                    logic [3:0] m;
                    m = ref_miss(d);
                    ev_valid[d][cyc+2] = 1'b1;
                    ev_miss[d][cyc+2]  = m;
                    ev_pred[d][cyc+2]  = d_p[d];
                    ev_predc[d][cyc+2] = d_pc[d];
                    if (m != 4'd0) begin
                        for (int k = 0; k < fh[d]; k++) ev_flush[d][cyc+2+k] = 1'b1;
                        squash_to[d]     = cyc + 2;
                        ev_inc[d][cyc+2] = 1'b1;
                    end
                end
                if (d_clr[d]) m_cnt[d] = 0;
                else if (ev_inc[d][cyc] && (m_cnt[d] < cmax[d])) m_cnt[d] = m_cnt[d] + 1;
            end
        end
    endtask

    task automatic check_all();
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                logic [127:0] exp_miss;
                exp_miss = ev_valid[d][cyc] ? 128'(ev_miss[d][cyc]) : 128'd0;
                chk("in_ready",  d, 128'(d == 0 ? bm.in_ready : ba.in_ready), 128'(!ev_flush[d][cyc]));
                chk("flush",     d, 128'(d == 0 ? flush_m : flush_a), 128'(ev_flush[d][cyc]));
                chk("out_valid", d, 128'(d == 0 ? bm.out_valid : ba.out_valid), 128'(ev_valid[d][cyc]));
                chk("lane_miss", d, 128'(d == 0 ? bm.out_lane_miss : ba.out_lane_miss), exp_miss);
                chk("miss_count", d, d == 0 ? 128'(cnt_m) : 128'(cnt_a), 128'(m_cnt[d]));
                if (ev_valid[d][cyc]) begin
                    chk("out_pred",     d, d == 0 ? bm.out_prediction : ba.out_prediction, ev_pred[d][cyc]);
                    chk("out_pred_col", d, 128'(d == 0 ? bm.out_prediction_col : ba.out_prediction_col),
                        128'(ev_predc[d][cyc]));
                end
            end
        end
    endtask

    task automatic step();
        apply();
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC - 8) begin
            $display("FAIL cycle_budget exceeded at cyc%0d", cyc);
            $fatal(1, "cycle budget");
        end
        if (!rst) started = 1'b1;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit found;
        checks = 0; errors = 0; cyc = 0; started = 1'b0;
        for (int d = 0; d < 2; d++) begin
            squash_to[d] = -1; m_cnt[d] = 0; d_clr[d] = 1'b0;
            mk_beat(d, 4'd0, 4'd0);
        end
        rst = 1'b0;

        repeat (3) begin
            mk_beat(0, 4'($urandom), 4'($urandom));
            mk_beat(1, 4'($urandom), 4'($urandom));
            step();
        end
        rst = 1'b1;

        for (int n = 0; n < 10; n++) begin
            mk_beat(0, 4'd0, 4'd0);
            mk_beat(1, 4'd0, 4'd0);
            step();
        end
        idle(0); idle(1);
        repeat (4) step();

        mk_beat(0, 4'd0, 4'd0);
        begin
            logic [31:0] base;
            base = $urandom;
            d_o1[0][2*OW +: OW] = base + 32'd7;
            d_o2[0][2*OW +: OW] = base;
            d_p[0][2*OW +: OW]  = 32'd6;
        end
        step();
        for (int n = 0; n < 9; n++) begin
            mk_beat(0, 4'd0, 4'd0);
            step();
        end
        chk("single_miss_count", 0, 128'(cnt_m), 128'd1);
        idle(0);
        repeat (3) step();

        for (int d = 0; d < 2; d++) begin
            mk_beat(d, 4'd0, 4'd0);
            for (int i = 0; i < L; i++) begin
                d_o1[d][i*OW +: OW] = 32'd0;
                d_o2[d][i*OW +: OW] = 32'd1;
                d_p[d][i*OW +: OW]  = 32'hFFFF_FFFF;
            end
        end
        step();
        idle(0); idle(1);
        repeat (3) step();

        mk_beat(0, 4'd0, 4'b0001);
        mk_beat(1, 4'd0, 4'b0001);
        step();
        idle(0); idle(1);
        repeat (8) step();

        for (int n = 0; n < 200; n++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 3) != 0)
                    mk_beat(d, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0,
                               ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0);
                else
                    idle(d);
            end
            d_clr[0] = ($urandom_range(0, 49) == 0);
            step();
        end
        d_clr[0] = 1'b0;
        idle(0);

        for (int n = 0; n < 60; n++) begin
            mk_beat(1, 4'b1000, 4'd0);
            step();
        end
        chk("saturate", 1, 128'(cnt_a), 128'd15);

        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            mk_beat(1, 4'b1000, 4'd0);
            d_clr[1] = ev_inc[1][cyc+1];
            found    = d_clr[1];
            step();
        end
        d_clr[1] = 1'b0;
        chk("clr_vs_inc_seen", 1, 128'(found), 128'd1);
        chk("clr_vs_inc", 1, 128'(cnt_a), 128'd0);
        idle(1);
        repeat (3) step();

        mk_beat(0, 4'b0001, 4'd0);
        step();
        idle(0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            found = ev_flush[0][cyc];
        end
        chk("flush_seen", 0, 128'(found), 128'd1);
        step();
        rst = 1'b0;
        step();
        chk("rst_mid_flush", 0, 128'(flush_m), 128'd0);
        chk("rst_mid_ready", 0, 128'(bm.in_ready), 128'd1);
        rst = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
